// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM port arbiter.
//   arb_state_t : access sequencer states (IDLE -> ISSUE -> WAIT -> DONE)
//   CNT_W       : width of the read-latency counter (RD_LAT up to 15)
//   MAX_CH      : largest supported channel count
//   pick_t      : result of a channel selection (found flag + winning index)
//   rr_pick()   : first set bit of mask at or after ptr, wrapping modulo nch
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam int CNT_W  = 4;
  localparam int MAX_CH = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // Fixed priority is the special case ptr == 0.
  function automatic pick_t rr_pick(input logic [MAX_CH-1:0] mask,
                                    input logic [2:0]        ptr,
                                    input int                nch);
    pick_t      r;
    logic [2:0] j;
    r.found = 1'b0;
    r.idx   = 3'd0;
    for (int k = 0; k < MAX_CH; k++) begin
      if (k < nch) begin
        j = 3'((int'(ptr) + k) % nch);
        if (!r.found && mask[j]) begin
          r.found = 1'b1;
          r.idx   = j;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_pick.sv
// Combinational channel selector.
//   mask  in  NCH  eligible channels
//   ptr   in  3    round-robin start index (ignored when RR == 0)
//   found out 1    at least one channel eligible
//   idx   out 3    winning channel index
module arb_pick
  import sdram_arb_pkg::*;
#(
  parameter int NCH = 4,
  parameter int RR  = 0
) (
  input  logic [NCH-1:0] mask,
  input  logic [2:0]     ptr,
  output logic           found,
  output logic [2:0]     idx
);

  pick_t             p;
  logic [MAX_CH-1:0] mask_ext;

  always_comb begin
    mask_ext          = '0;
    mask_ext[NCH-1:0] = mask;
    p                 = rr_pick(mask_ext, (RR != 0) ? ptr : 3'd0, NCH);
    found             = p.found;
    idx               = p.idx;
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Time-slices the single SDRAM port among NCH requesters. One access is started
// per slot_ena pulse seen while idle; the winner is chosen by fixed priority
// (RR=0, channel 0 highest) or round-robin (RR=1).
//   sys_clock, reset_n        clock, asynchronous active-low reset
//   slot_ena                  start-of-access-window pulse
//   ch_en, req_valid, req_we  per-channel enable / request / write flag
//   req_addr, req_din         packed per-channel address / write data
//   req_ready                 one-cycle accept pulse to the granted channel
//   rsp_valid, rsp_data       read-data pulse per channel, shared data bus
//   sd_addr, sd_din, sd_we, sd_oe, sd_dout   SDRAM controller side
//   busy                      an access is in progress
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int AW     = 25,
  parameter int DW     = 8,
  parameter int RR     = 0,
  parameter int RD_LAT = 5
) (
  input  logic              sys_clock,
  input  logic              reset_n,
  input  logic              slot_ena,
  input  logic [NCH-1:0]    ch_en,
  input  logic [NCH-1:0]    req_valid,
  input  logic [NCH-1:0]    req_we,
  input  logic [NCH*AW-1:0] req_addr,
  input  logic [NCH*DW-1:0] req_din,
  output logic [NCH-1:0]    req_ready,
  output logic [NCH-1:0]    rsp_valid,
  output logic [DW-1:0]     rsp_data,
  output logic [AW-1:0]     sd_addr,
  output logic [DW-1:0]     sd_din,
  output logic              sd_we,
  output logic              sd_oe,
  input  logic [DW-1:0]     sd_dout,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);
  localparam logic [2:0]       LAST_CH  = 3'(NCH - 1);

  arb_state_t       state;
  logic [2:0]       grant;
  logic [2:0]       rr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             is_rd;

  logic [NCH-1:0]   elig;
  logic             pick_found;
  logic [2:0]       pick_idx;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_din;
  logic             sel_we;

  assign elig = req_valid & ch_en;
  assign busy = (state != IDLE);

  arb_pick #(
    .NCH (NCH),
    .RR  (RR)
  ) u_pick (
    .mask  (elig),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Route the winner's request fields to the latch inputs.
  always_comb begin
    sel_addr = '0;
    sel_din  = '0;
    sel_we   = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (pick_idx == 3'(i)) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_din  = req_din[i*DW +: DW];
        sel_we   = req_we[i];
      end
    end
  end

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      grant     <= 3'd0;
      rr_ptr    <= 3'd0;
      cnt       <= '0;
      is_rd     <= 1'b0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      sd_addr   <= '0;
      sd_din    <= '0;
      sd_we     <= 1'b0;
      sd_oe     <= 1'b0;
    end else begin
      // Handshake pulses last exactly one cycle.
      req_ready <= '0;
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          // slot_ena is only honoured here; pulses during an access are dropped.
          if (slot_ena && pick_found) begin
            state     <= ISSUE;
            grant     <= pick_idx;
            rr_ptr    <= (pick_idx == LAST_CH) ? 3'd0 : pick_idx + 3'd1;
            req_ready <= NCH'(1) << pick_idx;
            sd_addr   <= sel_addr;
            sd_din    <= sel_din;
            sd_we     <= sel_we;
            sd_oe     <= ~sel_we;
            is_rd     <= ~sel_we;
          end
        end
        ISSUE: begin
          state <= WAIT;
          cnt   <= '0;
        end
        WAIT: begin
          if (cnt == CNT_LAST) begin
            state <= DONE;
            sd_we <= 1'b0;
            sd_oe <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          if (is_rd) begin
            rsp_data  <= sd_dout;
            rsp_valid <= NCH'(1) << grant;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
